// File: rtl/reset_sequencer.sv
// Reset and lock sequencer: synchronises PLL lock, enforces a reset hold, qualifies
// lock stability before releasing the application reset, and counts lock losses.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  output logic       reset_o,
  output logic       ready_o,
  output logic [1:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned LOSS_W = 8;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = '1;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOSS_W-1:0]      loss_q, loss_d;
  logic                   reset_q, ready_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock flag synchroniser; stage 0 samples the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  // Next-state, shared hold/stable counter and loss counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (soft_rst_i) begin
          state_d = ST_HOLD;
        end else if (locked_s) begin
          state_d = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (soft_rst_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = ST_HOLD;
          if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end else if (soft_rst_i) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and outputs, all registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      loss_q  <= '0;
      reset_q <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      reset_q <= (state_d != ST_RUN);
      ready_q <= (state_d == ST_RUN);
    end
  end

  assign reset_o         = reset_q;
  assign ready_o         = ready_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (SYNC=2, HOLD=4, LOCK=8).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic       soft_rst_i;
  logic       reset_o;
  logic       ready_o;
  logic [1:0] state_o;
  logic [7:0] lock_loss_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(4),
    .LOCK_CYCLES(8),
    .CNT_W      (11)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked_i),
    .soft_rst_i     (soft_rst_i),
    .reset_o        (reset_o),
    .ready_o        (ready_o),
    .state_o        (state_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic apply_reset(input logic lock);
    pll_locked_i = lock;
    soft_rst_i   = 1'b0;
    rst_n        = 1'b0;
    step(3);
    check("rst_reset", 32'(reset_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_cnt",   32'(lock_loss_cnt_o), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    for (int n = 0; n < 100 && state_o != s; n++) step(1);
    check(tag, 32'(state_o), 32'(s));
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_locked_i = 1'b0;
    soft_rst_i   = 1'b0;
    @(negedge clk);

    // 1: lock held high through reset; lock is already synchronised by WAIT_LOCK.
    apply_reset(1'b1);
    for (int i = 1; i <= 13; i++) begin
      logic [1:0] exp_s;
      step(1);
      exp_s = (i < 4) ? 2'd0 : (i == 4) ? 2'd1 : (i < 13) ? 2'd2 : 2'd3;
      check($sformatf("t1_state_%0d", i), 32'(state_o), 32'(exp_s));
      check($sformatf("t1_reset_%0d", i), 32'(reset_o), 32'(exp_s != 2'd3));
      check($sformatf("t1_ready_%0d", i), 32'(ready_o), 32'(exp_s == 2'd3));
    end
    check("t1_cnt", 32'(lock_loss_cnt_o), 32'd0);

    // 2: lock rises well after reset; release SYNC+LOCK = 10 edges later.
    apply_reset(1'b0);
    step(24);
    check("t2_wait", 32'(state_o), 32'd1);
    pll_locked_i = 1'b1;
    step(1);
    check("t2_wait_k0", 32'(state_o), 32'd1);
    step(1);
    check("t2_wait_k1", 32'(state_o), 32'd1);
    step(1);
    check("t2_stable_k2", 32'(state_o), 32'd2);
    step(7);
    check("t2_reset_k9", 32'(reset_o), 32'd1);
    step(1);
    check("t2_reset_k10", 32'(reset_o), 32'd0);
    check("t2_ready_k10", 32'(ready_o), 32'd1);
    check("t2_run_k10", 32'(state_o), 32'd3);

    // 3: locked_s sampled low at STABLE counter=5 for 3 cycles; qualification restarts.
    apply_reset(1'b1);
    step(8);
    pll_locked_i = 1'b0;
    step(2);
    check("t3_stable_e10", 32'(state_o), 32'd2);
    step(1);
    check("t3_wait_e11", 32'(state_o), 32'd1);
    pll_locked_i = 1'b1;
    step(2);
    check("t3_wait_e13", 32'(state_o), 32'd1);
    step(1);
    check("t3_stable_e14", 32'(state_o), 32'd2);
    step(7);
    check("t3_stable_e21", 32'(state_o), 32'd2);
    check("t3_reset_e21", 32'(reset_o), 32'd1);
    step(1);
    check("t3_run_e22", 32'(state_o), 32'd3);
    check("t3_cnt", 32'(lock_loss_cnt_o), 32'd0);

    // 4: lock loss in RUN; HOLD two edges after the pin falls, full 4-cycle HOLD.
    pll_locked_i = 1'b0;
    step(2);
    check("t4_run_k1", 32'(state_o), 32'd3);
    step(1);
    check("t4_hold", 32'(state_o), 32'd0);
    check("t4_reset", 32'(reset_o), 32'd1);
    check("t4_ready", 32'(ready_o), 32'd0);
    check("t4_cnt", 32'(lock_loss_cnt_o), 32'd1);
    step(3);
    check("t4_hold_3", 32'(state_o), 32'd0);
    step(1);
    check("t4_wait_4", 32'(state_o), 32'd1);
    pll_locked_i = 1'b1;
    wait_state(2'd3, "t4_rerun");

    // 5: soft reset in RUN, held through HOLD (ignored), then pulsed in STABLE.
    soft_rst_i = 1'b1;
    step(1);
    check("t5_run_soft", 32'(state_o), 32'd0);
    check("t5_run_cnt", 32'(lock_loss_cnt_o), 32'd1);
    step(3);
    check("t5_hold_soft", 32'(state_o), 32'd0);
    soft_rst_i = 1'b0;
    step(1);
    check("t5_wait", 32'(state_o), 32'd1);
    step(1);
    check("t5_stable", 32'(state_o), 32'd2);
    step(2);
    soft_rst_i = 1'b1;
    step(1);
    soft_rst_i = 1'b0;
    check("t5_stable_soft", 32'(state_o), 32'd0);
    check("t5_stable_cnt", 32'(lock_loss_cnt_o), 32'd1);
    step(4);
    check("t5_hold_len", 32'(state_o), 32'd1);

    // 6: 260 lock losses from RUN, one coincident with soft reset; saturates at 255.
    apply_reset(1'b1);
    for (int i = 0; i < 260; i++) begin
      pll_locked_i = 1'b1;
      wait_state(2'd3, $sformatf("t6_run_%0d", i));
      pll_locked_i = 1'b0;
      if (i == 100) begin
        step(2);
        soft_rst_i = 1'b1;
        step(1);
        soft_rst_i = 1'b0;
      end else begin
        step(3);
      end
      check($sformatf("t6_hold_%0d", i), 32'(state_o), 32'd0);
      check($sformatf("t6_cnt_%0d", i), 32'(lock_loss_cnt_o), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    pll_locked_i = 1'b1;
    wait_state(2'd2, "t6_stable");
    step(3);
    check("t6_stable_mid", 32'(state_o), 32'd2);
    check("t6_cnt_sat", 32'(lock_loss_cnt_o), 32'd255);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'(reset_o), 32'd1);
    check("t6_async_ready", 32'(ready_o), 32'd0);
    check("t6_async_state", 32'(state_o), 32'd0);
    check("t6_async_cnt", 32'(lock_loss_cnt_o), 32'd0);
    step(2);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
